// File: rtl/joker_ep1_in_arbiter.sv
// Round-robin owner of the shared EP1 IN buffer: grants one producer, forwards its writes, runs commit/ack.
// Optional grant watchdog is compiled in with JOKER_EP1_ARB_WDOG_EN.
`timescale 1ns/1ps
module joker_ep1_in_arbiter #(
    parameter int N           = 3,
    parameter int WDOG_CYCLES = 6024000,
    parameter int MAX_LEN     = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_commit,
    input  logic [N*11-1:0] req_addr,
    input  logic [N*8-1:0]  req_data,
    input  logic [N-1:0]    req_wren,
    input  logic [N*11-1:0] req_len,
    output logic [N-1:0]    req_grant,
    output logic [N-1:0]    req_done,
    output logic [N-1:0]    req_abort,
    input  logic            usb_in_ready,
    input  logic            usb_in_commit_ack,
    output logic            usb_in_commit,
    output logic [10:0]     usb_in_addr,
    output logic [7:0]      usb_in_data,
    output logic            usb_in_wren,
    output logic [10:0]     usb_in_commit_len,
    output logic            busy
);
    localparam int              GW        = (N > 1) ? $clog2(N) : 1;
    localparam logic [10:0]     MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [GW-1:0]   LAST_RST  = GW'(N - 1);
    localparam logic [N-1:0]    ONE       = N'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_COMMIT,
        ST_RELEASE
    } state_t;

    state_t        state, state_d;
    logic [GW-1:0] g_q, g_d;
    logic [GW-1:0] last_q, last_d;
    logic          ack_prev;
    logic          ack_fall;

    logic [N-1:0]  grant_d, done_d, abort_d;
    logic          commit_d, wren_d;
    logic [10:0]   addr_d, len_d;
    logic [7:0]    data_d;

    logic          sel_valid, sel_commit, sel_wren;
    logic [10:0]   sel_addr, sel_len;
    logic [7:0]    sel_data;

    logic          hi_found, lo_found;
    logic [GW-1:0] hi_idx, lo_idx, pick_idx;
    logic          pick_found;

    logic          wdog_hit;

    // Handshake: a requester raises req_valid and keeps it high until it sees
    // req_done or req_abort; it may write only while req_grant is set, and
    // req_commit is a single-cycle pulse that is honoured only from the grantee.
    // Toward the USB core, usb_in_commit stays high until the ack falls (1 -> 0).

    assign busy     = (state != ST_IDLE);
    assign ack_fall = ack_prev && !usb_in_commit_ack;

    always_comb begin
        sel_valid  = 1'b0;
        sel_commit = 1'b0;
        sel_wren   = 1'b0;
        sel_addr   = '0;
        sel_len    = '0;
        sel_data   = '0;
        for (int i = 0; i < N; i++) begin
            if (g_q == GW'(i)) begin
                sel_valid  = req_valid[i];
                sel_commit = req_commit[i];
                sel_wren   = req_wren[i];
                sel_addr   = req_addr[i*11 +: 11];
                sel_len    = req_len[i*11 +: 11];
                sel_data   = req_data[i*8 +: 8];
            end
        end
    end

    // First requester above last wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!hi_found && req_valid[i] && (GW'(i) > last_q)) begin
                hi_found = 1'b1;
                hi_idx   = GW'(i);
            end
            if (!lo_found && req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = GW'(i);
            end
        end
        pick_found = lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

`ifdef JOKER_EP1_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_q, wdog_d;

    assign wdog_hit = (wdog_q == WW'(WDOG_CYCLES - 1));

    always_comb begin
        wdog_d = '0;
        if (state == ST_GRANT) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    // Watchdog compiled out; the parameter stays so both builds share one interface.
    assign wdog_hit = 1'b0 & (WDOG_CYCLES > 0);
`endif

    always_comb begin
        state_d  = state;
        g_d      = g_q;
        last_d   = last_q;
        grant_d  = req_grant;
        done_d   = '0;
        abort_d  = '0;
        commit_d = usb_in_commit;
        len_d    = usb_in_commit_len;
        addr_d   = usb_in_addr;
        data_d   = usb_in_data;
        wren_d   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (usb_in_ready && pick_found) begin
                    grant_d = ONE << pick_idx;
                    g_d     = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                addr_d = sel_addr;
                data_d = sel_data;
                wren_d = sel_wren;
                if (sel_commit) begin
                    commit_d = 1'b1;
                    len_d    = (sel_len > MAX_LEN_L) ? MAX_LEN_L : sel_len;
                    state_d  = ST_COMMIT;
                end else if (!sel_valid || wdog_hit) begin
                    abort_d = ONE << g_q;
                    grant_d = '0;
                    state_d = ST_RELEASE;
                    if (wdog_hit) begin
                        wren_d = 1'b0;
                    end
                end
            end
            ST_COMMIT: begin
                if (ack_fall) begin
                    commit_d = 1'b0;
                    done_d   = ONE << g_q;
                    grant_d  = '0;
                    state_d  = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                last_d  = g_q;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d  = '0;
                commit_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= ST_IDLE;
            g_q               <= '0;
            last_q            <= LAST_RST;
            ack_prev          <= 1'b0;
            req_grant         <= '0;
            req_done          <= '0;
            req_abort         <= '0;
            usb_in_commit     <= 1'b0;
            usb_in_addr       <= '0;
            usb_in_data       <= '0;
            usb_in_wren       <= 1'b0;
            usb_in_commit_len <= '0;
        end else begin
            state             <= state_d;
            g_q               <= g_d;
            last_q            <= last_d;
            ack_prev          <= usb_in_commit_ack;
            req_grant         <= grant_d;
            req_done          <= done_d;
            req_abort         <= abort_d;
            usb_in_commit     <= commit_d;
            usb_in_addr       <= addr_d;
            usb_in_data       <= data_d;
            usb_in_wren       <= wren_d;
            usb_in_commit_len <= len_d;
        end
    end

endmodule

// File: tb/tb_joker_ep1_in_arbiter.sv
// Directed bench for joker_ep1_in_arbiter (N = 3); watchdog steps run when JOKER_EP1_ARB_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_joker_ep1_in_arbiter;
    localparam int N  = 3;
    localparam int AW = N * 11;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_commit;
    logic [N*11-1:0] req_addr;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    req_wren;
    logic [N*11-1:0] req_len;
    logic [N-1:0]    req_grant;
    logic [N-1:0]    req_done;
    logic [N-1:0]    req_abort;
    logic            usb_in_ready;
    logic            usb_in_commit_ack;
    logic            usb_in_commit;
    logic [10:0]     usb_in_addr;
    logic [7:0]      usb_in_data;
    logic            usb_in_wren;
    logic [10:0]     usb_in_commit_len;
    logic            busy;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [19:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    joker_ep1_in_arbiter #(
        .N(N),
        .WDOG_CYCLES(100),
        .MAX_LEN(1024)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_commit(req_commit),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_wren(req_wren),
        .req_len(req_len),
        .req_grant(req_grant),
        .req_done(req_done),
        .req_abort(req_abort),
        .usb_in_ready(usb_in_ready),
        .usb_in_commit_ack(usb_in_commit_ack),
        .usb_in_commit(usb_in_commit),
        .usb_in_addr(usb_in_addr),
        .usb_in_data(usb_in_data),
        .usb_in_wren(usb_in_wren),
        .usb_in_commit_len(usb_in_commit_len),
        .busy(busy)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_len(input int i, input logic [10:0] len);
        req_len = (req_len & ~(AW'(11'h7FF) << (i * 11))) | (AW'(len) << (i * 11));
    endtask

    // Commit on requester i (already granted), ack high two cycles then low.
    task automatic serve(input int i, input logic [10:0] len, input logic [10:0] exp_len);
        logic [N-1:0] bit_i;
        bit_i = N'(1) << i;
        req_commit = bit_i;
        set_len(i, len);
        tick();
        req_commit = '0;
        check("commit_raise", 32'(usb_in_commit), 32'd1);
        check("commit_len", 32'(usb_in_commit_len), 32'(exp_len));
        check("wren_low_in_commit", 32'(usb_in_wren), 32'd0);
        usb_in_commit_ack = 1'b1;
        tick();
        tick();
        check("commit_hold_ack_high", 32'({usb_in_commit, req_done}), 32'({1'b1, 3'b000}));
        usb_in_commit_ack = 1'b0;
        tick();
        check("done_pulse", 32'(req_done), 32'(bit_i));
        check("commit_drop", 32'(usb_in_commit), 32'd0);
        check("grant_drop", 32'(req_grant), 32'd0);
    endtask

    // Counts ungranted cycles (the done cycle included) until the next grant.
    task automatic wait_grant(input string tag, input logic [N-1:0] exp_grant);
        int gap;
        gap = 1;
        for (int c = 0; c < 10 && req_grant == '0; c++) begin
            tick();
            if (req_grant == '0) gap++;
        end
        check({tag, "_gap"}, 32'(gap), 32'd2);
        check(tag, 32'(req_grant), 32'(exp_grant));
    endtask

    initial begin
        logic [10:0] a;
        logic [7:0]  d;
        logic [19:0] exp_w;

        reset             = 1'b0;
        req_valid         = '0;
        req_commit        = '0;
        req_addr          = '0;
        req_data          = '0;
        req_wren          = '0;
        req_len           = '0;
        usb_in_ready      = 1'b0;
        usb_in_commit_ack = 1'b0;
        repeat (3) tick();

        check("rst_grant", 32'(req_grant), 32'd0);
        check("rst_done", 32'(req_done), 32'd0);
        check("rst_abort", 32'(req_abort), 32'd0);
        check("rst_commit", 32'(usb_in_commit), 32'd0);
        check("rst_wren", 32'(usb_in_wren), 32'd0);
        check("rst_len", 32'(usb_in_commit_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Requester 1 alone; requester 0 writes too but holds no grant.
        reset        = 1'b1;
        usb_in_ready = 1'b1;
        req_valid    = 3'b010;
        tick();
        check("grant_r1", 32'(req_grant), 32'b010);
        check("busy_grant", 32'(busy), 32'd1);
        for (int i = 0; i < 64; i++) begin
            a        = 11'(i);
            d        = (i % 2 == 0) ? 8'hAA : 8'h55;
            req_addr = {11'h000, a, 11'h7FF};
            req_data = {8'h00, d, 8'h3C};
            req_wren = 3'b011;
            exp_q.push_back({1'b1, a, d});
            tick();
            exp_w = exp_q.pop_front();
            check("write_fwd", 32'({usb_in_wren, usb_in_addr, usb_in_data}), 32'(exp_w));
        end
        req_wren = '0;
        serve(1, 11'd64, 11'd64);
        req_valid = '0;
        tick();
        check("done_single_pulse", 32'(req_done), 32'd0);
        check("idle_after_release", 32'(busy), 32'd0);

        // Reset while the commit is outstanding.
        req_valid = 3'b001;
        tick();
        check("grant_r0_wrap", 32'(req_grant), 32'b001);
        req_commit = 3'b001;
        set_len(0, 11'd5);
        tick();
        req_commit = '0;
        check("commit_before_rst", 32'(usb_in_commit), 32'd1);
        reset = 1'b0;
        tick();
        check("mrst_grant", 32'(req_grant), 32'd0);
        check("mrst_done", 32'(req_done), 32'd0);
        check("mrst_abort", 32'(req_abort), 32'd0);
        check("mrst_commit", 32'(usb_in_commit), 32'd0);
        check("mrst_addr", 32'(usb_in_addr), 32'd0);
        check("mrst_data", 32'(usb_in_data), 32'd0);
        check("mrst_wren", 32'(usb_in_wren), 32'd0);
        check("mrst_len", 32'(usb_in_commit_len), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        tick();
        check("mrst_no_pulse", 32'({req_done, req_abort}), 32'd0);

        // All three requesting: 0, 1, 2, 0 with two idle cycles between grants.
        req_valid = 3'b111;
        reset     = 1'b1;
        tick();
        check("rr_first_after_rst", 32'(req_grant), 32'b001);
        serve(0, 11'd2000, 11'd1024);
        wait_grant("rr_second", 3'b010);
        serve(1, 11'd0, 11'd0);
        wait_grant("rr_third", 3'b100);
        serve(2, 11'd1024, 11'd1024);
        wait_grant("rr_fourth", 3'b001);
        serve(0, 11'd1023, 11'd1023);
        req_valid = '0;
        tick();

        // Requester 0 withdraws while granted.
        req_valid = 3'b001;
        tick();
        check("abort_setup_grant", 32'(req_grant), 32'b001);
        req_valid = 3'b010;
        tick();
        check("abort_r0", 32'(req_abort), 32'b001);
        check("abort_no_commit", 32'(usb_in_commit), 32'd0);
        check("abort_grant_drop", 32'(req_grant), 32'd0);
        tick();
        check("abort_single_pulse", 32'(req_abort), 32'd0);
        tick();
        check("grant_after_abort", 32'(req_grant), 32'b010);
        req_commit   = 3'b001;
        usb_in_ready = 1'b0;
        tick();
        req_commit = '0;
        check("foreign_commit_ignored", 32'(usb_in_commit), 32'd0);
        check("ready_ignored_in_grant", 32'(req_grant), 32'b010);
        req_valid = 3'b100;
        tick();
        check("abort_r1", 32'(req_abort), 32'b010);
        tick();
        tick();
        check("ready_low_no_grant", 32'(req_grant), 32'd0);
        usb_in_ready = 1'b1;
        tick();
        check("grant_r2_ready", 32'(req_grant), 32'b100);
        req_valid = '0;
        tick();
        check("abort_r2", 32'(req_abort), 32'b100);
        tick();

`ifdef JOKER_EP1_ARB_WDOG_EN
        // Stalled grant revoked after 100 cycles; a commit on cycle 100 wins.
        req_valid = 3'b100;
        tick();
        check("wdog_grant", 32'(req_grant), 32'b100);
        repeat (99) tick();
        check("wdog_not_early", 32'({req_grant, req_abort}), 32'({3'b100, 3'b000}));
        tick();
        check("wdog_abort", 32'(req_abort), 32'b100);
        check("wdog_wren_low", 32'(usb_in_wren), 32'd0);
        tick();
        tick();
        check("wdog_regrant", 32'(req_grant), 32'b100);
        repeat (99) tick();
        req_commit = 3'b100;
        set_len(2, 11'd10);
        tick();
        req_commit = '0;
        check("wdog_commit_wins", 32'({usb_in_commit, req_abort}), 32'({1'b1, 3'b000}));
        usb_in_commit_ack = 1'b1;
        tick();
        usb_in_commit_ack = 1'b0;
        tick();
        check("wdog_commit_done", 32'(req_done), 32'b100);
        req_valid = '0;
        tick();
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
